imm_pixel_feeder: RTL and testbench

Raster-scan image reader that drives the pixel input side of the image masking accelerator (imm). On a start pulse it walks the frame row-major from image RAM and presents image_pixel, pixel_row and pixel_col with a valid/ready handshake. It is the source the masking datapath consumes. It sits between the image frame RAM (1-cycle synchronous read) and imm's image_pixel/pixel_row/pixel_col inputs.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_skid_buf.sv | 67 ++++++
 rtl/imm_pixel_feeder.sv | 124 ++++++++++++
 tb/tb_imm_pixel_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared widths and types for the image masking accelerator pixel feeder.
package imm_pkg;

   localparam int PIX_W = 12;
   localparam int ROW_W = 9;
   localparam int COL_W = 8;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      logic             last;
   } pix_tag_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry FIFO of {pixel, tag}; entry 0 is the registered head presented downstream.
module imm_skid_buf
   import imm_pkg::*;
#(
   parameter int DATA_W = PIX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  pix_tag_t          push_tag,
   input  logic              pop,
   output logic [1:0]        count,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data,
   output pix_tag_t          head_tag
);

   logic [DATA_W-1:0] tail_data;
   pix_tag_t          tail_tag;
   logic              pop_ok;

   assign pop_ok     = pop && (count != 2'd0);
   assign head_valid = (count != 2'd0);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count     <= 2'd0;
         head_data <= '0;
         head_tag  <= '0;
         tail_data <= '0;
         tail_tag  <= '0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (count == 2'd0) begin
                  head_data <= push_data;
                  head_tag  <= push_tag;
               end else begin
                  tail_data <= push_data;
                  tail_tag  <= push_tag;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               head_data <= tail_data;
               head_tag  <= tail_tag;
               count     <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_data <= push_data;
                  head_tag  <= push_tag;
               end else begin
                  head_data <= tail_data;
                  head_tag  <= tail_tag;
                  tail_data <= push_data;
                  tail_tag  <= push_tag;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/imm_pixel_feeder.sv
// Row-major frame reader: streams image RAM words with (row, col, last) tags to the imm datapath.
//   state | meaning
//   IDLE  | waiting for start; base address latched on start
//   SCAN  | issuing one read per slot while the skid buffer has room
//   DRAIN | all reads issued; waiting for the last pixel, then one done cycle
module imm_pixel_feeder
   import imm_pkg::*;
#(
   parameter int IMG_ROWS = 320,
   parameter int IMG_COLS = 240,
   parameter int PIX_W    = imm_pkg::PIX_W,
   parameter int ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  image_pixel,
   output logic [ROW_W-1:0]  pixel_row,
   output logic [COL_W-1:0]  pixel_col,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);

   feeder_state_t     state_q, state_d;
   logic [ROW_W-1:0]  row_q;
   logic [COL_W-1:0]  col_q;
   logic [ADDR_W-1:0] addr_q;
   logic              inflight_q;
   pix_tag_t          inflight_tag_q;
   logic              done_q;

   logic [1:0]        buf_count;
   logic              head_valid;
   logic [PIX_W-1:0]  head_data;
   pix_tag_t          head_tag;

   logic              pop, issue, at_last, accept_start;
   logic [1:0]        occupancy;

   assign pop          = head_valid && out_ready;
   assign occupancy    = buf_count + {1'b0, inflight_q};
   assign at_last      = (row_q == LAST_ROW) && (col_q == LAST_COL);
   assign accept_start = (state_q == IDLE) && start && !abort;

   // A pop this cycle frees a slot for the read landing next cycle, which keeps 1 pixel/clk.
   assign issue = (state_q == SCAN) && !abort && ((occupancy < 2'd2) || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         row_q          <= '0;
         col_q          <= '0;
         addr_q         <= '0;
         inflight_q     <= 1'b0;
         inflight_tag_q <= '0;
         done_q         <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         done_q     <= (state_q == DRAIN) && pop && head_tag.last && !abort;
         if (accept_start) begin
            addr_q <= base_addr;
            row_q  <= '0;
            col_q  <= '0;
         end else if (issue) begin
            addr_q         <= addr_q + ADDR_W'(1);
            inflight_tag_q <= '{row: row_q, col: col_q, last: at_last};
            if (col_q == LAST_COL) begin
               col_q <= '0;
               row_q <= row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (issue && at_last) state_d = DRAIN;
         DRAIN:   if (done_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   imm_skid_buf #(.DATA_W(PIX_W)) u_skid_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (abort),
      .push       (inflight_q),
      .push_data  (mem_rdata),
      .push_tag   (inflight_tag_q),
      .pop        (pop),
      .count      (buf_count),
      .head_valid (head_valid),
      .head_data  (head_data),
      .head_tag   (head_tag)
   );

   assign mem_en      = issue;
   assign mem_addr    = addr_q;
   assign out_valid   = head_valid;
   assign image_pixel = head_data;
   assign pixel_row   = head_tag.row;
   assign pixel_col   = head_tag.col;
   assign out_last    = head_valid && head_tag.last;
   assign busy        = (state_q != IDLE) && !done_q;
   assign done        = done_q;

endmodule

// File: tb/tb_imm_pixel_feeder.sv
// Directed bench for imm_pixel_feeder: a 3x4 frame instance and a 1x1 frame instance.
module tb_imm_pixel_feeder;

   localparam int COLS = 4;
   localparam int NPIX = 12;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, abort, out_ready;
   logic [16:0] base_addr;
   logic        mem_en;
   logic [16:0] mem_addr;
   logic [11:0] mem_rdata;
   logic        out_valid, out_last, busy, done;
   logic [11:0] image_pixel;
   logic [8:0]  pixel_row;
   logic [7:0]  pixel_col;

   logic        s_start, s_abort, s_out_ready;
   logic [16:0] s_base_addr;
   logic        s_mem_en;
   logic [16:0] s_mem_addr;
   logic [11:0] s_mem_rdata;
   logic        s_out_valid, s_out_last, s_busy, s_done;
   logic [11:0] s_image_pixel;
   logic [8:0]  s_pixel_row;
   logic [7:0]  s_pixel_col;

   int n_vec = 0;
   int n_err = 0;

   imm_pixel_feeder #(.IMG_ROWS(3), .IMG_COLS(4), .PIX_W(12), .ADDR_W(17)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .image_pixel(image_pixel),
      .pixel_row(pixel_row), .pixel_col(pixel_col), .out_last(out_last),
      .busy(busy), .done(done)
   );

   imm_pixel_feeder #(.IMG_ROWS(1), .IMG_COLS(1), .PIX_W(12), .ADDR_W(17)) dut_one (
      .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .base_addr(s_base_addr),
      .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .image_pixel(s_image_pixel),
      .pixel_row(s_pixel_row), .pixel_col(s_pixel_col), .out_last(s_out_last),
      .busy(s_busy), .done(s_done)
   );

   // image RAM: word at address a holds a
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem_addr[11:0];
      if (s_mem_en) s_mem_rdata <= s_mem_addr[11:0];
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no finish, expected finish before 100us");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic to_sample();
      @(negedge clk);
   endtask

   // Entered at a drive point; returns at a sample point.
   task automatic scan_frame(input logic [16:0] base, input bit bp, input int abort_at,
                             input int restart_at);
      int          t, idx, issued, last_t;
      bit          ended, acc;
      logic [3:0]  pat;
      logic [16:0] ea;
      pat = 4'b1001;
      start = 1'b1; abort = 1'b0; out_ready = 1'b1; base_addr = base;
      to_drive();
      t = 1; idx = 0; issued = 0; last_t = 0; ended = 1'b0;
      while (!ended && t < 120) begin
         start     = (t == restart_at);
         base_addr = 17'h1ABCD;
         out_ready = bp ? pat[(t - 1) % 4] : 1'b1;
         abort     = (abort_at > 0) && out_valid && out_ready && (idx == abort_at - 1);
         to_sample();
         acc = out_valid && out_ready;
         if ((issued >= NPIX) || (issued - idx - int'(acc) >= 2))
            check("mem_en_budget", 32'(mem_en), 32'(0));
         if (mem_en) begin
            ea = base + 17'(issued);
            check("mem_addr", 32'(mem_addr), 32'(ea));
            issued++;
         end
         if (!bp) check("out_valid", 32'(out_valid), 32'((t >= 3) && (idx < NPIX)));
         if (out_valid) begin
            ea = base + 17'(idx);
            check("image_pixel", 32'(image_pixel), 32'(ea[11:0]));
            check("pixel_row", 32'(pixel_row), idx / COLS);
            check("pixel_col", 32'(pixel_col), idx % COLS);
            check("out_last", 32'(out_last), 32'(idx == NPIX - 1));
         end else begin
            check("out_last_idle", 32'(out_last), 32'(0));
         end
         check("done", 32'(done), 32'((last_t != 0) && (t == last_t + 1)));
         if ((last_t != 0) && (t == last_t + 1)) begin
            check("busy_at_done", 32'(busy), 32'(0));
            check("pixel_count", idx, NPIX);
            ended = 1'b1;
         end else begin
            check("busy", 32'(busy), 32'(1));
         end
         if (acc) begin
            idx++;
            if (idx == NPIX) last_t = t;
         end
         if (abort) begin
            to_drive();
            abort = 1'b0; start = 1'b0;
            to_sample();
            check("abort_valid", 32'(out_valid), 32'(0));
            check("abort_busy", 32'(busy), 32'(0));
            check("abort_done", 32'(done), 32'(0));
            ended = 1'b1;
         end
         if (!ended) begin
            to_drive();
            t++;
         end
      end
      check("frame_ended", 32'(ended), 32'(1));
      start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         to_drive();
         to_sample();
         check("idle_valid", 32'(out_valid), 32'(0));
         check("idle_done", 32'(done), 32'(0));
         check("idle_mem_en", 32'(mem_en), 32'(0));
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; base_addr = '0;
      s_start = 1'b0; s_abort = 1'b0; s_out_ready = 1'b1; s_base_addr = '0;
      to_drive();
      to_drive();
      to_sample();
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_mem_en", 32'(mem_en), 32'(0));
      check("rst_mem_addr", 32'(mem_addr), 32'(0));
      check("rst_image_pixel", 32'(image_pixel), 32'(0));
      check("rst_out_last", 32'(out_last), 32'(0));
      to_drive();
      rst_n = 1'b1;
      to_drive();

      scan_frame(17'h10, 1'b0, 0, 0);
      to_drive();
      scan_frame(17'h10, 1'b1, 0, 0);
      to_drive();
      scan_frame(17'h10, 1'b0, 5, 0);
      to_drive();
      scan_frame(17'h00, 1'b0, 0, 0);
      to_drive();
      scan_frame(17'h10, 1'b0, 0, 6);

      // reset for one edge in the middle of SCAN
      to_drive();
      start = 1'b1; base_addr = 17'h10;
      to_drive();
      start = 1'b0;
      repeat (5) to_drive();
      rst_n = 1'b0;
      to_drive();
      rst_n = 1'b1;
      to_sample();
      check("mid_rst_out_valid", 32'(out_valid), 32'(0));
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_done", 32'(done), 32'(0));
      check("mid_rst_mem_en", 32'(mem_en), 32'(0));
      check("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
      check("mid_rst_pixel", 32'(image_pixel), 32'(0));
      check("mid_rst_row", 32'(pixel_row), 32'(0));
      check("mid_rst_col", 32'(pixel_col), 32'(0));
      check("mid_rst_last", 32'(out_last), 32'(0));
      to_drive();
      scan_frame(17'h20, 1'b0, 0, 0);

      // start and abort together: abort wins
      to_drive();
      start = 1'b1; abort = 1'b1; base_addr = 17'h40;
      to_drive();
      start = 1'b0; abort = 1'b0;
      to_sample();
      check("start_abort_busy", 32'(busy), 32'(0));
      check("start_abort_mem_en", 32'(mem_en), 32'(0));
      to_drive();
      to_sample();
      check("start_abort_valid", 32'(out_valid), 32'(0));
      check("start_abort_mem_en2", 32'(mem_en), 32'(0));

      // 1x1 frame
      to_drive();
      s_start = 1'b1; s_base_addr = 17'h5;
      to_drive();
      s_start = 1'b0; s_base_addr = 17'h0;
      to_sample();
      check("one_mem_en", 32'(s_mem_en), 32'(1));
      check("one_mem_addr", 32'(s_mem_addr), 32'(5));
      check("one_busy", 32'(s_busy), 32'(1));
      to_drive();
      to_sample();
      check("one_mem_en_off", 32'(s_mem_en), 32'(0));
      check("one_valid_early", 32'(s_out_valid), 32'(0));
      to_drive();
      to_sample();
      check("one_valid", 32'(s_out_valid), 32'(1));
      check("one_pixel", 32'(s_image_pixel), 32'(5));
      check("one_row", 32'(s_pixel_row), 32'(0));
      check("one_col", 32'(s_pixel_col), 32'(0));
      check("one_last", 32'(s_out_last), 32'(1));
      check("one_done_early", 32'(s_done), 32'(0));
      to_drive();
      to_sample();
      check("one_done", 32'(s_done), 32'(1));
      check("one_valid_after", 32'(s_out_valid), 32'(0));
      check("one_busy_after", 32'(s_busy), 32'(0));
      to_drive();
      to_sample();
      check("one_done_pulse", 32'(s_done), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
